// File: rtl/fifo_wptr_full.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wptr_full
// Description : Async-FIFO write-domain pointer, full/almost-full and level.
//               Optional sticky overflow flag when FIFO_WOVF_FLAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wptr_full #(
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  wafull,
`ifdef FIFO_WOVF_FLAG_EN
  output logic                  wovf,
`endif
  output logic [ADDR_WIDTH:0]   wlevel
);

  localparam logic [ADDR_WIDTH:0] c_AFULL_LEVEL = (ADDR_WIDTH+1)'(AFULL_LEVEL);

  logic [ADDR_WIDTH:0] wbin_q, wbin_d;
  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] wlevel_q, wlevel_d;
  logic [ADDR_WIDTH:0] rbin;
  logic                wfull_q, wfull_d;
  logic                wafull_q, wafull_d;

  assign wen    = winc & ~wfull_q;
  assign wbin_d = wbin_q + {{ADDR_WIDTH{1'b0}}, wen};
  assign wptr_d = (wbin_d >> 1) ^ wbin_d;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  assign wlevel_d = wbin_d - rbin;
  assign wafull_d = (wlevel_d >= c_AFULL_LEVEL);
  // Full when the next write pointer is one lap ahead of the read pointer.
  assign wfull_d  = (wptr_d == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1],
                                wq2_rptr[ADDR_WIDTH-2:0]});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
    end
  end

  assign waddr  = wbin_q[ADDR_WIDTH-1:0];
  assign wptr   = wptr_q;
  assign wfull  = wfull_q;
  assign wafull = wafull_q;
  assign wlevel = wlevel_q;

`ifdef FIFO_WOVF_FLAG_EN
  logic wovf_q, wovf_d;

  assign wovf_d = wovf_q | (winc & wfull_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wovf_q <= 1'b0;
    end else begin
      wovf_q <= wovf_d;
    end
  end

  assign wovf = wovf_q;
`endif

endmodule
`default_nettype wire

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-domain pointer and flag generator for the asynchronous FIFO.
- Sits directly upstream of the write-side pointer synchronizer. Its registered Gray write pointer is the value that the synchronizer carries into the read domain.
- Consumes the read pointer after it has been synchronized into the write domain, and produces:
  - the memory write address
  - the write enable
  - full, almost-full and a fill level

Parameters:
- ADDR_WIDTH, 4, FIFO address bits; depth = 2**ADDR_WIDTH; must be >= 2.
- AFULL_LEVEL, 12, fill level at or above which wafull asserts; legal range 1..2**ADDR_WIDTH.

Ports:
- clk  input  1  write-domain clock.
- rst  input  1  asynchronous active-high reset.
- winc  input  1  write request from the producer.
- wq2_rptr  input  ADDR_WIDTH+1  Gray read pointer, already double-flopped into the clk domain.
- wen  output  1  memory write enable.
- waddr  output  ADDR_WIDTH  memory write address.
- wptr  output  ADDR_WIDTH+1  registered Gray write pointer, drives the synchronizer toward the read domain.
- wfull  output  1  FIFO full, registered.
- wafull  output  1  FIFO almost full, registered.
- wlevel  output  ADDR_WIDTH+1  write-side fill level, registered, range 0..2**ADDR_WIDTH.

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. Reset clears wbin, wptr, wfull, wafull, wlevel (and wovf, when present) to 0 immediately, independent of clk.
- Reset mid-operation: the pointer returns to 0 and every flag clears on assertion; no write is accepted while rst is high.
- Internal register wbin, ADDR_WIDTH+1 bits, is the binary write pointer.
- Write acceptance:
  - wen = winc & ~wfull, combinational.
  - A write is accepted on any clk edge where wen=1.
- Next-pointer computation:
  - wbin_next = wbin + wen, modulo 2**(ADDR_WIDTH+1); the MSB is the wrap bit.
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- Register update on each clk edge:
  - wbin <= wbin_next
  - wptr <= wgray_next
- waddr = wbin[ADDR_WIDTH-1:0], from the register with no extra logic.
- The write at the current waddr happens in the same cycle as wen.
- wptr never depends combinationally on any input; it is a pure flop output. Consecutive wptr values differ in exactly 1 bit.
- Full flag:
  - wfull <= (wgray_next == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]}), where A = ADDR_WIDTH.
  - wfull rises on the edge that accepts the 2**A-th outstanding write. There is no extra cycle of latency.
  - wfull falls only after wq2_rptr changes. This is pessimistic by the synchronizer delay, which is by design.
- Read-pointer conversion:
  - rbin = Gray-to-binary of wq2_rptr.
  - rbin[A] = g[A]; rbin[i] = rbin[i+1] ^ g[i].
- Fill level:
  - wlevel <= wbin_next - rbin, modulo 2**(A+1).
  - The result is always in 0..2**A given a legal wq2_rptr.
- Almost-full flag:
  - wafull <= (wbin_next - rbin) >= AFULL_LEVEL.
  - wafull has the same timing as wfull.
  - wfull=1 implies wafull=1.
- Write while full: winc=1 with wfull=1 gives wen=0. The pointer, address and level are unchanged, and the data is dropped silently.
- Wrap-around: after 2**(A+1) accepted writes, wbin returns to 0 and wptr returns to 0. This is continuous, with no special case.
- Simultaneous events: a write acceptance and a wq2_rptr advance in the same cycle are both reflected in the next wfull, wafull and wlevel values.

Optional Feature:
- Macro: FIFO_WOVF_FLAG_EN.
- Defined:
  - Adds output port wovf, 1 bit.
  - wovf is a sticky overflow flag. It is set on the clk edge where winc=1 and wfull=1.
  - It stays 1 until rst, and resets to 0.
- Undefined:
  - The port and its register are absent.
  - Writes while full are dropped silently, and nothing else changes.

Test Plan (ADDR_WIDTH=4, AFULL_LEVEL=12):
1. Fill to full: hold wq2_rptr=0 and pulse winc 16 times. Required response:
   - waddr steps 0..15 then back to 0.
   - wlevel=16 and wptr=5'b11000, gray(16).
   - wfull=1 on the edge of the 16th write.
   - wafull=1 from the edge of the 12th write (wlevel=12).
2. Write while full: from the full state, hold winc=1 for 3 cycles. Required response:
   - wen=0 throughout.
   - wptr, waddr and wlevel unchanged.
   - wovf=1 and stays 1 (with the feature enabled); no wovf port without it.
3. Drain and release: from full, step wq2_rptr to gray(4)=5'b00110. Required response:
   - wfull=0 and wlevel=12, one edge later.
   - wafull stays 1.
   - Step wq2_rptr to gray(5)=5'b00111: wafull=0 and wlevel=11.
4. Simultaneous: at wlevel=15, winc=1 and wq2_rptr advances by 1 in the same cycle. Required response: wlevel stays 15, wfull stays 0, wptr advances.
5. Wrap and Gray check: perform 64 writes with wq2_rptr tracking wptr (level kept under 16). Required response:
   - Every wptr transition changes exactly 1 bit.
   - wptr returns to 0 after 32 writes.
   - wfull is never asserted.
6. Asynchronous reset mid-fill: after 7 writes, assert rst between clk edges. Required response:
   - wptr, waddr, wlevel, wfull, wafull and wovf are 0 before the next edge.
   - After release, the first write uses waddr=0.
